// File: rtl/lvds_word_align.sv
// Recovers 7-bit word boundaries on a 4-lane LVDS link from the clock-lane pattern.
// Optional LOCKED-state mismatch counter on O_err_cnt when LVDS_ALIGN_ERR_CNT_EN is defined.
module lvds_word_align #(
  parameter logic [6:0]  CLK_PATTERN = 7'b1100011,
  parameter int unsigned LOCK_CNT    = 8,
  parameter int unsigned LOSS_CNT    = 4
) (
  input  logic        I_clk_1x,
  input  logic        I_rst,
  input  logic [6:0]  I_clk_lane_data,
  input  logic [6:0]  I_data0,
  input  logic [6:0]  I_data1,
  input  logic [6:0]  I_data2,
  input  logic [6:0]  I_data3,
  output logic        O_align_valid0,
  output logic        O_align_valid1,
  output logic        O_align_valid2,
  output logic        O_align_valid3,
  output logic [6:0]  O_align_data0,
  output logic [6:0]  O_align_data1,
  output logic [6:0]  O_align_data2,
  output logic [6:0]  O_align_data3,
  output logic        O_lock,
  output logic [2:0]  O_shift
`ifdef LVDS_ALIGN_ERR_CNT_EN
  ,
  output logic [15:0] O_err_cnt
`endif
);

  localparam logic [7:0] LockCntW = 8'(LOCK_CNT);
  localparam logic [7:0] LossCntW = 8'(LOSS_CNT);

  typedef enum logic [1:0] {
    StSearch  = 2'd0,
    StConfirm = 2'd1,
    StLocked  = 2'd2
  } state_e;

  // Lane 0 is the clock lane, lanes 1..4 are data lanes 0..3.
  logic [4:0][6:0] lanes_in;
  logic [4:0][6:0] cur_q;
  logic [4:0][6:0] prev_q;
  logic [1:0]      fill_q;

  state_e     state_q, state_d;
  logic [2:0] shift_q, shift_d;
  logic [7:0] match_cnt_q, match_cnt_d;
  logic [7:0] miss_cnt_q, miss_cnt_d;

  logic            valid_q;
  logic [3:0][6:0] align_data_q;

  logic [13:0] clk_w;
  logic        eval;
  logic        cur_match;
  logic        hit;
  logic [2:0]  hit_shift;
  logic        locked;

  function automatic logic [6:0] cand(input logic [13:0] w, input logic [2:0] s);
    cand = w[{1'b0, s} +: 7];
  endfunction

  assign lanes_in = {I_data3, I_data2, I_data1, I_data0, I_clk_lane_data};

  // Stage 1: current and previous word of every lane.
  always_ff @(posedge I_clk_1x or posedge I_rst) begin
    if (I_rst) begin
      cur_q  <= '0;
      prev_q <= '0;
      fill_q <= 2'd0;
    end else begin
      cur_q  <= lanes_in;
      prev_q <= cur_q;
      if (fill_q != 2'd2) begin
        fill_q <= fill_q + 2'd1;
      end
    end
  end

  assign clk_w     = {prev_q[0], cur_q[0]};
  assign eval      = (fill_q == 2'd2);
  assign cur_match = (cand(clk_w, shift_q) == CLK_PATTERN);
  assign locked    = (state_q == StLocked);

  // Lowest matching shift wins, hence the descending scan.
  always_comb begin
    hit       = 1'b0;
    hit_shift = 3'd0;
    for (int s = 6; s >= 0; s--) begin
      if (cand(clk_w, 3'(s)) == CLK_PATTERN) begin
        hit       = 1'b1;
        hit_shift = 3'(s);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    if (eval) begin
      unique case (state_q)
        StSearch: begin
          if (hit) begin
            shift_d     = hit_shift;
            match_cnt_d = 8'd1;
            state_d     = StConfirm;
          end
        end
        StConfirm: begin
          if (cur_match) begin
            if (match_cnt_q + 8'd1 >= LockCntW) begin
              match_cnt_d = 8'd0;
              miss_cnt_d  = 8'd0;
              state_d     = StLocked;
            end else begin
              match_cnt_d = match_cnt_q + 8'd1;
            end
          end else begin
            match_cnt_d = 8'd0;
            state_d     = StSearch;
          end
        end
        StLocked: begin
          if (cur_match) begin
            miss_cnt_d = 8'd0;
          end else if (miss_cnt_q + 8'd1 >= LossCntW) begin
            miss_cnt_d  = 8'd0;
            match_cnt_d = 8'd0;
            state_d     = StSearch;
          end else begin
            miss_cnt_d = miss_cnt_q + 8'd1;
          end
        end
        default: begin
          state_d     = StSearch;
          match_cnt_d = 8'd0;
          miss_cnt_d  = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge I_clk_1x or posedge I_rst) begin
    if (I_rst) begin
      state_q     <= StSearch;
      shift_q     <= 3'd0;
      match_cnt_q <= 8'd0;
      miss_cnt_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  // Stage 2: aligned output words, zeroed whenever not locked.
  always_ff @(posedge I_clk_1x or posedge I_rst) begin
    if (I_rst) begin
      valid_q      <= 1'b0;
      align_data_q <= '0;
    end else begin
      valid_q <= locked;
      for (int i = 0; i < 4; i++) begin
        align_data_q[i] <= locked ? cand({prev_q[i+1], cur_q[i+1]}, shift_q) : 7'h00;
      end
    end
  end

`ifdef LVDS_ALIGN_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge I_clk_1x or posedge I_rst) begin
    if (I_rst) begin
      err_cnt_q <= 16'h0000;
    end else if (eval && locked && !cur_match && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'h0001;
    end
  end

  assign O_err_cnt = err_cnt_q;
`endif

  assign O_align_valid0 = valid_q;
  assign O_align_valid1 = valid_q;
  assign O_align_valid2 = valid_q;
  assign O_align_valid3 = valid_q;
  assign O_align_data0  = align_data_q[0];
  assign O_align_data1  = align_data_q[1];
  assign O_align_data2  = align_data_q[2];
  assign O_align_data3  = align_data_q[3];
  assign O_lock         = locked;
  assign O_shift        = shift_q;

endmodule

// File: tb/tb_lvds_word_align.sv
// Directed bench for lvds_word_align: search, confirm, lock, loss, reset and latency.
module tb_lvds_word_align;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] clk_lane, d0, d1, d2, d3;
  logic       v0, v1, v2, v3;
  logic [6:0] q0, q1, q2, q3;
  logic       lock;
  logic [2:0] shift;
`ifdef LVDS_ALIGN_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  lvds_word_align dut (
    .I_clk_1x        (clk),
    .I_rst           (rst),
    .I_clk_lane_data (clk_lane),
    .I_data0         (d0),
    .I_data1         (d1),
    .I_data2         (d2),
    .I_data3         (d3),
    .O_align_valid0  (v0),
    .O_align_valid1  (v1),
    .O_align_valid2  (v2),
    .O_align_valid3  (v3),
    .O_align_data0   (q0),
    .O_align_data1   (q1),
    .O_align_data2   (q2),
    .O_align_data3   (q3),
    .O_lock          (lock),
`ifdef LVDS_ALIGN_ERR_CNT_EN
    .O_err_cnt       (err_cnt),
`endif
    .O_shift         (shift)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Holds reset across one edge; release lands 1 time unit after that edge.
  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  task automatic set_data(input logic [6:0] a, b, c, d);
    d0 = a; d1 = b; d2 = c; d3 = d;
  endtask

  initial begin
    rst      = 1'b1;
    clk_lane = 7'b0011110;
    set_data(7'h55, 7'h55, 7'h55, 7'h55);
    #1;
    check("rst_lock",  {15'd0, lock},  16'd0);
    check("rst_shift", {13'd0, shift}, 16'd0);
    check("rst_valid", {15'd0, v0},    16'd0);
    check("rst_data",  {9'd0, q0},     16'd0);

    // Clock lane 0011110: pattern found at shift 3, data 55 realigns to 5A.
    tick(1);
    rst = 1'b0;
    tick(9);
    check("s3_lock_r9",  {15'd0, lock},  16'd0);
    check("s3_shift_r9", {13'd0, shift}, 16'd3);
    tick(1);
    check("s3_lock_r10",  {15'd0, lock}, 16'd1);
    check("s3_valid_r10", {15'd0, v0},   16'd0);
    tick(1);
    check("s3_valid0", {15'd0, v0}, 16'd1);
    check("s3_valid3", {15'd0, v3}, 16'd1);
    check("s3_data0",  {9'd0, q0},  16'h5A);
    check("s3_data1",  {9'd0, q1},  16'h5A);
    check("s3_data2",  {9'd0, q2},  16'h5A);
    check("s3_data3",  {9'd0, q3},  16'h5A);

    // Clock lane at the pattern itself: shift 0, pass-through with 2-clock latency.
    clk_lane = 7'b1100011;
    set_data(7'h11, 7'h22, 7'h33, 7'h44);
    do_reset();
    tick(11);
    check("s0_shift", {13'd0, shift}, 16'd0);
    check("s0_valid", {15'd0, v1},    16'd1);
    check("s0_data0", {9'd0, q0},     16'h11);
    check("s0_data3", {9'd0, q3},     16'h44);
    set_data(7'h2B, 7'h4C, 7'h6D, 7'h0E);
    tick(1);
    check("lat_data0_1clk", {9'd0, q0}, 16'h11);
    tick(1);
    check("lat_data0", {9'd0, q0}, 16'h2B);
    check("lat_data1", {9'd0, q1}, 16'h4C);
    check("lat_data2", {9'd0, q2}, 16'h6D);
    check("lat_data3", {9'd0, q3}, 16'h0E);

    // Bad word after 5 confirm matches restarts the search.
    do_reset();
    tick(6);
    clk_lane = 7'h00;
    tick(1);
    clk_lane = 7'b1100011;
    tick(1);
    check("cfm_lock_after_bad", {15'd0, lock}, 16'd0);
    tick(7);
    check("cfm_lock_r15", {15'd0, lock}, 16'd0);
    tick(1);
    check("cfm_relock", {15'd0, lock}, 16'd1);

    // 3 bad then 1 good holds lock; 4 bad drops it.
    clk_lane = 7'h00;
    tick(3);
    clk_lane = 7'b1100011;
    tick(1);
    check("loss_hold_3bad", {15'd0, lock}, 16'd1);
    clk_lane = 7'h00;
    tick(4);
    check("loss_lock_3miss", {15'd0, lock}, 16'd1);
    tick(1);
    check("loss_lock_drop",  {15'd0, lock}, 16'd0);
    check("loss_valid_lag",  {15'd0, v0},   16'd1);
    tick(1);
    check("loss_valid_drop", {15'd0, v2},   16'd0);
    check("loss_data_zero",  {9'd0, q2},    16'h00);

    // Reset asserted mid-lock clears everything at once; relock takes 10 edges.
    clk_lane = 7'b0011110;
    set_data(7'h55, 7'h55, 7'h55, 7'h55);
    do_reset();
    tick(11);
    check("pre_rst_shift", {13'd0, shift}, 16'd3);
    check("pre_rst_valid", {15'd0, v0},    16'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_lock",  {15'd0, lock},  16'd0);
    check("mid_rst_shift", {13'd0, shift}, 16'd0);
    check("mid_rst_valid", {15'd0, v0},    16'd0);
    check("mid_rst_data",  {9'd0, q1},     16'd0);
    #1;
    rst = 1'b0;
    tick(9);
    check("relock_r9",  {15'd0, lock}, 16'd0);
    tick(1);
    check("relock_r10", {15'd0, lock}, 16'd1);

`ifdef LVDS_ALIGN_ERR_CNT_EN
    clk_lane = 7'b1100011;
    do_reset();
    tick(10);
    for (int k = 0; k < 2; k++) begin
      clk_lane = 7'h00;
      tick(3);
      clk_lane = 7'b1100011;
      tick(1);
    end
    tick(1);
    check("err_cnt_6", err_cnt, 16'd6);
    check("err_lock",  {15'd0, lock}, 16'd1);
    @(negedge clk);
    force dut.err_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.err_cnt_q;
    clk_lane = 7'h00;
    tick(2);
    clk_lane = 7'b1100011;
    tick(2);
    check("err_cnt_sat", err_cnt, 16'hFFFF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
